// File: rtl/mem_arb_pkg.sv
// Shared types and encodings for the memory arbiter.
// No logic, no latency.
// No flow control; types only.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    ABORT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IF   = 2'd1,
    GNT_LD   = 2'd2,
    GNT_ST   = 2'd3
  } grant_t;

  // size[1:0] encodings and the sign-extend flag position in size[2]
  localparam logic [1:0] SZ_BYTE   = 2'd0;
  localparam logic [1:0] SZ_HALF   = 2'd1;
  localparam logic [1:0] SZ_WORD   = 2'd2;
  localparam int         SZ_SIGNED = 2;

  // controller length code for a full-word fetch
  localparam logic [2:0] LEN_WORD = {1'b0, SZ_WORD};

endpackage

// File: rtl/mem_arb_pick.sv
// Priority picker: chooses which requester wins an idle arbitration.
// Purely combinational, zero latency.
// No backpressure; the caller only samples the result while idle.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   if_valid,
  input  logic   ld_valid,
  input  logic   st_valid,
  input  logic   starve_hit,
  input  logic   flush_mask,
  output grant_t grant
);

  // Starved fetch beats everything; otherwise stores, then loads, then fetch.
  // A flush removes the speculative requesters but never a committed store.
  always_comb begin
    grant = GNT_NONE;
    if (starve_hit && if_valid && !flush_mask) begin
      grant = GNT_IF;
    end else if (st_valid) begin
      grant = GNT_ST;
    end else if (ld_valid && !flush_mask) begin
      grant = GNT_LD;
    end else if (if_valid && !flush_mask) begin
      grant = GNT_IF;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the memory controller between fetch, load and store requesters.
// Grant registered one cycle after request; ready returns in the mc_ready cycle.
// Requesters hold valid until ready; rdy_in low freezes everything.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  input  logic        rob_clear,
  input  logic        if_valid,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_data,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  input  logic [2:0]  ld_size,
  output logic        ld_ready,
  output logic [31:0] ld_data,
  input  logic        st_valid,
  input  logic [31:0] st_addr,
  input  logic [2:0]  st_size,
  input  logic [31:0] st_data,
  output logic        st_ready,
  output logic        mc_valid,
  output logic        mc_wr,
  output logic [31:0] mc_addr,
  output logic [2:0]  mc_len,
  output logic [31:0] mc_data,
  output logic        mc_abort,
  input  logic        mc_ready,
  input  logic [31:0] mc_res,
  output logic        busy
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  state_t        state_q, state_d;
  grant_t        grant_q, grant_d;
  grant_t        pick;
  logic [CW-1:0] starve_q, starve_d;
  logic          wr_q, wr_d;
  logic [31:0]   addr_q, addr_d;
  logic [2:0]    len_q, len_d;
  logic [31:0]   data_q, data_d;

  logic starve_hit;
  logic kill;
  logic deliver;

  assign starve_hit = (starve_q == CW'(STARVE_LIMIT));

  // a flush cancels only speculative work; stores always run to completion
  assign kill = rdy_in && rob_clear && (state_q == BUSY) &&
                ((grant_q == GNT_IF) || (grant_q == GNT_LD));

  assign deliver = rdy_in && (state_q == BUSY) && mc_ready && !kill;

  mem_arb_pick u_pick (
    .if_valid   (if_valid),
    .ld_valid   (ld_valid),
    .st_valid   (st_valid),
    .starve_hit (starve_hit),
    .flush_mask (rob_clear),
    .grant      (pick)
  );

  // Next state, grant, latched operands and starve counter; all hold when rdy_in is low.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    starve_d = starve_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    len_d    = len_q;
    data_d   = data_q;
    if (rdy_in) begin
      unique case (state_q)
        IDLE: begin
          if (pick != GNT_NONE) begin
            state_d = BUSY;
            grant_d = pick;
            unique case (pick)
              GNT_IF: begin
                wr_d   = 1'b0;
                addr_d = if_addr;
                len_d  = LEN_WORD;
                data_d = 32'd0;
              end
              GNT_LD: begin
                wr_d   = 1'b0;
                addr_d = ld_addr;
                len_d  = ld_size;
                data_d = 32'd0;
              end
              default: begin
                wr_d   = 1'b1;
                addr_d = st_addr;
                len_d  = st_size;
                data_d = st_data;
              end
            endcase
          end
        end
        BUSY: begin
          if (kill) begin
            state_d = ABORT;
            grant_d = GNT_NONE;
          end else if (mc_ready) begin
            state_d = IDLE;
            grant_d = GNT_NONE;
          end
        end
        default: begin
          state_d = IDLE;
          grant_d = GNT_NONE;
        end
      endcase

      // fetch waiting counter: cleared by a fetch grant, an idle fetch port or a flush
      if (!if_valid || rob_clear) begin
        starve_d = '0;
      end else if ((state_q == IDLE) && (pick == GNT_IF)) begin
        starve_d = '0;
      end else if ((grant_q != GNT_IF) && !starve_hit) begin
        starve_d = starve_q + CW'(1);
      end
    end
  end

  // State and operand registers, cleared asynchronously so a reset drops any transaction.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= IDLE;
      grant_q  <= GNT_NONE;
      starve_q <= '0;
      wr_q     <= 1'b0;
      addr_q   <= 32'd0;
      len_q    <= 3'd0;
      data_q   <= 32'd0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      starve_q <= starve_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      data_q   <= data_d;
    end
  end

  assign mc_valid = (state_q == BUSY) && !kill;
  assign mc_abort = (state_q == ABORT);
  assign busy     = (state_q != IDLE);
  assign mc_wr    = wr_q;
  assign mc_addr  = addr_q;
  assign mc_len   = len_q;
  assign mc_data  = data_q;

  assign if_ready = deliver && (grant_q == GNT_IF);
  assign ld_ready = deliver && (grant_q == GNT_LD);
  assign st_ready = deliver && (grant_q == GNT_ST);
  assign if_data  = mc_res;
  assign ld_data  = mc_res;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter (STARVE_LIMIT=3).
// Stimulus pushes expected controller requests and requester responses;
// a negedge monitor pops and compares them as the DUT presents them.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  len;
    logic [31:0] data;
  } req_t;

  typedef struct packed {
    logic [1:0]  port;
    logic [31:0] data;
  } rsp_t;

  logic        clk_in = 1'b0;
  logic        rst_n_in, rdy_in, rob_clear;
  logic        if_valid, ld_valid, st_valid;
  logic [31:0] if_addr, ld_addr, st_addr, st_data;
  logic [2:0]  ld_size, st_size;
  logic        if_ready, ld_ready, st_ready;
  logic [31:0] if_data, ld_data;
  logic        mc_valid, mc_wr, mc_abort, mc_ready, busy;
  logic [31:0] mc_addr, mc_data, mc_res;
  logic [2:0]  mc_len;

  int checks   = 0;
  int failures = 0;

  req_t exp_req_q[$];
  rsp_t exp_rsp_q[$];
  logic mcv_prev = 1'b0;

  always #5 clk_in = ~clk_in;

  mem_arbiter #(.STARVE_LIMIT(3)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .rob_clear(rob_clear),
    .if_valid(if_valid), .if_addr(if_addr), .if_ready(if_ready), .if_data(if_data),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_size(ld_size),
    .ld_ready(ld_ready), .ld_data(ld_data),
    .st_valid(st_valid), .st_addr(st_addr), .st_size(st_size), .st_data(st_data),
    .st_ready(st_ready),
    .mc_valid(mc_valid), .mc_wr(mc_wr), .mc_addr(mc_addr), .mc_len(mc_len),
    .mc_data(mc_data), .mc_abort(mc_abort), .mc_ready(mc_ready), .mc_res(mc_res),
    .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic push_req(input logic wr, input logic [31:0] a, input logic [2:0] l,
                          input logic [31:0] d);
    req_t r;
    r.wr = wr; r.addr = a; r.len = l; r.data = d;
    exp_req_q.push_back(r);
  endtask

  task automatic push_rsp(input logic [1:0] p, input logic [31:0] d);
    rsp_t r;
    r.port = p; r.data = d;
    exp_rsp_q.push_back(r);
  endtask

  // Monitor: every new controller request and every ready pulse must match the next expectation.
  always @(negedge clk_in) begin
    req_t er;
    rsp_t es;
    rsp_t as;
    int   nrdy;
    if (rst_n_in) begin
      if (mc_valid && !mcv_prev) begin
        checks++;
        if (exp_req_q.size() == 0) begin
          failures++;
          $display("FAIL mc_req unexpected addr=%h", mc_addr);
        end else begin
          er = exp_req_q.pop_front();
          if ({mc_wr, mc_addr, mc_len, mc_data} !== er) begin
            failures++;
            $display("FAIL mc_req got wr=%b addr=%h len=%h data=%h expected wr=%b addr=%h len=%h data=%h",
                     mc_wr, mc_addr, mc_len, mc_data, er.wr, er.addr, er.len, er.data);
          end
        end
      end
      nrdy = int'(if_ready) + int'(ld_ready) + int'(st_ready);
      if (nrdy > 1) begin
        checks++;
        failures++;
        $display("FAIL multi_ready got if=%b ld=%b st=%b expected one", if_ready, ld_ready, st_ready);
      end else if (nrdy == 1) begin
        as.port = if_ready ? 2'd1 : (ld_ready ? 2'd2 : 2'd3);
        as.data = if_ready ? if_data : (ld_ready ? ld_data : 32'd0);
        checks++;
        if (exp_rsp_q.size() == 0) begin
          failures++;
          $display("FAIL rsp unexpected port=%0d data=%h", as.port, as.data);
        end else begin
          es = exp_rsp_q.pop_front();
          if (as !== es) begin
            failures++;
            $display("FAIL rsp got port=%0d data=%h expected port=%0d data=%h",
                     as.port, as.data, es.port, es.data);
          end
        end
      end
    end
    mcv_prev = mc_valid;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] pat2;
    rst_n_in = 1'b0; rdy_in = 1'b1; rob_clear = 1'b0;
    if_valid = 1'b0; ld_valid = 1'b0; st_valid = 1'b0;
    if_addr = '0; ld_addr = '0; st_addr = '0; st_data = '0; ld_size = '0; st_size = '0;
    mc_ready = 1'b0; mc_res = '0;
    repeat (2) @(posedge clk_in);

    // reset values
    @(negedge clk_in);
    chk("rst_mc_valid", 32'(mc_valid), 32'd0);
    chk("rst_mc_abort", 32'(mc_abort), 32'd0);
    chk("rst_mc_wr", 32'(mc_wr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_readys", {29'd0, if_ready, ld_ready, st_ready}, 32'd0);
    chk("rst_mc_addr", mc_addr, 32'd0);
    chk("rst_mc_len", 32'(mc_len), 32'd0);
    chk("rst_mc_data", mc_data, 32'd0);
    cyc(); rst_n_in = 1'b1;

    // single fetch: granted at edge 0, mc_valid cycles 1..5, ready at 5
    cyc(); if_valid = 1'b1; if_addr = 32'h1000;
    push_req(1'b0, 32'h1000, LEN_WORD, 32'd0);
    push_rsp(2'd1, 32'h00100093);
    @(negedge clk_in); chk("t1_mcv_c0", 32'(mc_valid), 32'd0);
    for (int c = 1; c <= 5; c++) begin
      cyc();
      if (c == 5) begin mc_ready = 1'b1; mc_res = 32'h00100093; end
      @(negedge clk_in);
      chk("t1_mcv", 32'(mc_valid), 32'd1);
      chk("t1_busy", 32'(busy), 32'd1);
      if (c == 5) chk("t1_if_ready", 32'(if_ready), 32'd1);
    end
    cyc(); mc_ready = 1'b0; if_valid = 1'b0;
    @(negedge clk_in);
    chk("t1_after_mcv", 32'(mc_valid), 32'd0);
    chk("t1_after_state", 32'(dut.state_q), 32'(IDLE));

    // simultaneous ST, LD, IF with zero-latency controller
    pat2 = 7'b0101010;
    for (int i = 0; i <= 6; i++) begin
      cyc();
      case (i)
        0: begin
          st_valid = 1'b1; st_addr = 32'h2000; st_data = 32'hDEADBEEF; st_size = 3'd2;
          ld_valid = 1'b1; ld_addr = 32'h3000; ld_size = 3'd2;
          if_valid = 1'b1; if_addr = 32'h1004;
          push_req(1'b1, 32'h2000, 3'd2, 32'hDEADBEEF);
          push_req(1'b0, 32'h3000, 3'd2, 32'd0);
          push_req(1'b0, 32'h1004, LEN_WORD, 32'd0);
          push_rsp(2'd3, 32'd0);
          push_rsp(2'd2, 32'h11111111);
          push_rsp(2'd1, 32'h22222222);
        end
        1: mc_ready = 1'b1;
        2: begin mc_ready = 1'b0; st_valid = 1'b0; end
        3: begin mc_ready = 1'b1; mc_res = 32'h11111111; end
        4: begin mc_ready = 1'b0; ld_valid = 1'b0; end
        5: begin mc_ready = 1'b1; mc_res = 32'h22222222; end
        default: begin mc_ready = 1'b0; if_valid = 1'b0; end
      endcase
      @(negedge clk_in);
      chk("t2_mcv_pattern", 32'(mc_valid), 32'(pat2[i]));
    end

    // starvation: ST and LD stay valid, fetch must win once it has waited 3 cycles
    for (int i = 0; i <= 10; i++) begin
      cyc();
      case (i)
        0: begin
          st_valid = 1'b1; st_addr = 32'h2100; st_data = 32'h1; st_size = 3'd2;
          ld_valid = 1'b1; ld_addr = 32'h3300; ld_size = 3'd1;
          if_valid = 1'b1; if_addr = 32'h1008;
          push_req(1'b1, 32'h2100, 3'd2, 32'h1);
          push_req(1'b0, 32'h1008, LEN_WORD, 32'd0);
          push_req(1'b1, 32'h2200, 3'd2, 32'h2);
          push_req(1'b0, 32'h3300, 3'd1, 32'd0);
          push_rsp(2'd3, 32'd0);
          push_rsp(2'd1, 32'h55555555);
          push_rsp(2'd3, 32'd0);
          push_rsp(2'd2, 32'h66666666);
        end
        2: mc_ready = 1'b1;
        3: begin mc_ready = 1'b0; st_addr = 32'h2200; st_data = 32'h2; end
        5: begin mc_ready = 1'b1; mc_res = 32'h55555555; end
        6: begin mc_ready = 1'b0; if_valid = 1'b0; end
        7: mc_ready = 1'b1;
        8: begin mc_ready = 1'b0; st_valid = 1'b0; end
        9: begin mc_ready = 1'b1; mc_res = 32'h66666666; end
        10: begin mc_ready = 1'b0; ld_valid = 1'b0; end
        default: ;
      endcase
      @(negedge clk_in);
      if (i == 3) chk("t3_starve_cnt", 32'(dut.starve_q), 32'd3);
      if (i == 4) begin
        chk("t3_if_wins_mcv", 32'(mc_valid), 32'd1);
        chk("t3_if_wins_addr", mc_addr, 32'h1008);
      end
    end

    // flush during load with mc_ready in the same cycle
    cyc(); ld_valid = 1'b1; ld_addr = 32'h3100; ld_size = 3'b101;
    push_req(1'b0, 32'h3100, 3'b101, 32'd0);
    cyc(); @(negedge clk_in); chk("t4_mcv", 32'(mc_valid), 32'd1);
    cyc(); rob_clear = 1'b1; mc_ready = 1'b1; mc_res = 32'hFFFF0000;
    @(negedge clk_in);
    chk("t4_ld_ready_suppressed", 32'(ld_ready), 32'd0);
    chk("t4_mcv_dropped", 32'(mc_valid), 32'd0);
    cyc(); rob_clear = 1'b0; mc_ready = 1'b0; ld_valid = 1'b0;
    @(negedge clk_in);
    chk("t4_abort", 32'(mc_abort), 32'd1);
    chk("t4_abort_state", 32'(dut.state_q), 32'(ABORT));
    chk("t4_abort_mcv", 32'(mc_valid), 32'd0);
    cyc(); @(negedge clk_in);
    chk("t4_abort_off", 32'(mc_abort), 32'd0);
    chk("t4_idle", 32'(dut.state_q), 32'(IDLE));
    chk("t4_starve_cnt", 32'(dut.starve_q), 32'd0);

    // flush during store: store completes, fetch masked in an idle flush cycle
    cyc(); st_valid = 1'b1; st_addr = 32'h2400; st_size = 3'd0; st_data = 32'hA5;
    push_req(1'b1, 32'h2400, 3'd0, 32'hA5);
    push_rsp(2'd3, 32'd0);
    cyc();
    cyc(); rob_clear = 1'b1; if_valid = 1'b1; if_addr = 32'h1010;
    @(negedge clk_in);
    chk("t5_store_kept", 32'(mc_valid), 32'd1);
    cyc(); rob_clear = 1'b0; mc_ready = 1'b1;
    @(negedge clk_in);
    chk("t5_no_abort", 32'(mc_abort), 32'd0);
    chk("t5_st_ready", 32'(st_ready), 32'd1);
    cyc(); mc_ready = 1'b0; st_valid = 1'b0; rob_clear = 1'b1;
    push_req(1'b0, 32'h1010, LEN_WORD, 32'd0);
    push_rsp(2'd1, 32'h77777777);
    cyc(); rob_clear = 1'b0;
    @(negedge clk_in); chk("t5_if_masked", 32'(mc_valid), 32'd0);
    cyc(); @(negedge clk_in); chk("t5_if_after_mask", 32'(mc_valid), 32'd1);
    cyc(); mc_ready = 1'b1; mc_res = 32'h77777777;
    cyc(); mc_ready = 1'b0; if_valid = 1'b0;

    // rdy_in low for 4 cycles mid-BUSY while mc_ready is pulsed
    cyc(); ld_valid = 1'b1; ld_addr = 32'h3200; ld_size = 3'd2;
    push_req(1'b0, 32'h3200, 3'd2, 32'd0);
    push_rsp(2'd2, 32'h44444444);
    cyc();
    for (int c = 0; c < 4; c++) begin
      cyc(); rdy_in = 1'b0; mc_ready = 1'b1; mc_res = 32'h00000BAD; ld_addr = 32'h9999;
      @(negedge clk_in);
      chk("t6_frozen_ready", 32'(ld_ready), 32'd0);
      chk("t6_frozen_state", 32'(dut.state_q), 32'(BUSY));
      chk("t6_frozen_addr", mc_addr, 32'h3200);
    end
    cyc(); rdy_in = 1'b1; mc_res = 32'h44444444;
    @(negedge clk_in); chk("t6_ld_ready", 32'(ld_ready), 32'd1);
    cyc(); mc_ready = 1'b0; ld_valid = 1'b0;

    // asynchronous reset in the middle of a fetch
    cyc(); if_valid = 1'b1; if_addr = 32'h1020;
    push_req(1'b0, 32'h1020, LEN_WORD, 32'd0);
    cyc(); @(negedge clk_in); chk("t7_mcv_before", 32'(mc_valid), 32'd1);
    #2; rst_n_in = 1'b0; #1;
    chk("t7_mcv_async", 32'(mc_valid), 32'd0);
    chk("t7_busy_async", 32'(busy), 32'd0);
    if_valid = 1'b0;
    cyc(); cyc(); rst_n_in = 1'b1;
    repeat (3) cyc();
    @(negedge clk_in);
    chk("t7_idle", 32'(dut.state_q), 32'(IDLE));
    chk("end_req_q_empty", 32'(exp_req_q.size()), 32'd0);
    chk("end_rsp_q_empty", 32'(exp_rsp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port arbiter that shares the byte-serial memory controller between three requesters: instruction fetch, speculative loads, and committed stores. It sits between the fetch unit, load/store unit and store buffer on one side and the memory controller on the other. It latches one request at a time and drives it to the controller. It routes the result back and handles pipeline flushes: speculative work is cancelled, committed stores are never lost. Instruction fetch has an anti-starvation counter so a steady load/store stream cannot block fetch indefinitely.

## Interface
- STARVE_LIMIT, 8: consecutive cycles fetch may wait un-granted before it is forced to win the next arbitration (1..15).
- clk_in  in  1  system clock.
- rst_n_in  in  1  reset; asynchronous, active-low.
- rdy_in  in  1  global enable; low freezes all state.
- rob_clear  in  1  pipeline flush, one-cycle pulse.
- if_valid / if_addr  in  1 / 32  fetch request, word read.
- if_ready / if_data  out  1 / 32  fetch done, fetched word.
- ld_valid / ld_addr / ld_size  in  1 / 32 / 3  load request; size[1:0]: 0 byte, 1 half, 2 word; size[2]: signed.
- ld_ready / ld_data  out  1 / 32  load done, load result.
- st_valid / st_addr / st_size / st_data  in  1 / 32 / 3 / 32  committed store.
- st_ready  out  1  store done.
- mc_valid / mc_wr / mc_addr / mc_len / mc_data  out  1 / 1 / 32 / 3 / 32  controller request.
- mc_abort  out  1  one-cycle cancel of the in-flight controller transaction.
- mc_ready / mc_res  in  1 / 32  controller done, read result.
- busy  out  1  a transaction is granted (state BUSY or ABORT).

## Operation
- States: IDLE, BUSY, ABORT. Grant register values: NONE, IF, LD, ST.
- IDLE: pick a winner from the valid requesters.
  - Default priority: ST > LD > IF.
  - If the starve counter equals STARVE_LIMIT and if_valid is high, IF wins.
  - On a win: latch addr/size/data/wr of the winner into the mc_* registers, set grant, go to BUSY.
  - The IF request uses mc_len = 3'b010 and mc_wr = 0.
- BUSY: mc_valid is held high.
  - On mc_ready: pulse the granted requester's ready, clear grant, go to IDLE.
  - Requester result data is mc_res, routed combinationally.
- Flush (rob_clear high) in BUSY with grant IF or LD:
  - drop mc_valid, assert mc_abort, go to ABORT.
  - No ready is delivered, even if mc_ready is high in the same cycle.
- Flush in BUSY with grant ST: no effect; the store completes normally.
- Flush in IDLE: IF and LD are masked from arbitration that cycle; ST may still be granted.
- ABORT: mc_abort high for exactly one cycle, then IDLE. Requests are ignored while in ABORT.
- Starve counter:
  - Increments each cycle that if_valid is high and grant != IF; saturates at STARVE_LIMIT.
  - Clears when IF is granted, when if_valid is low, or on rob_clear.
  - Width is clog2(STARVE_LIMIT+1).
- rdy_in low: state, grant, counter and mc_* registers hold; ready outputs are forced 0.

## Timing
- Reset values: state IDLE, grant NONE, counter 0. mc_valid, mc_abort, mc_wr, busy, if_ready, ld_ready and st_ready are all 0. mc_addr, mc_len and mc_data are 0.
- Request seen in IDLE at edge t: mc_valid and busy are high from t+1.
- x_ready is asserted in the same cycle as mc_ready, for exactly 1 cycle.
- Back-to-back: after mc_ready at cycle k, IDLE is entered at k+1. The next mc_valid rises at k+2 at the earliest.
- Requesters hold valid and their operands until ready. The arbiter latches operands at grant, so changes after grant are ignored.
- rob_clear and mc_ready in the same cycle:
  - grant LD/IF: ready suppressed, ABORT entered.
  - grant ST: st_ready asserted.
- Reset asserted mid-transaction: all outputs clear immediately (asynchronous); no ready is delivered.

## Structure
- Package mem_arb_pkg holds the following; no other shared constants.
  - the state enum (IDLE, BUSY, ABORT)
  - the grant enum (NONE=0, IF=1, LD=2, ST=3)
  - the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_SIGNED bit)
  - LEN_WORD = 3'b010
- Sub-module mem_arb_pick: combinational priority picker. Inputs are the three valids, starve_hit and flush_mask; output is the grant encoding.
- The FSM, starve counter and mc_* registers live in mem_arbiter.

## Test plan
- Single fetch: if_valid, if_addr=0x1000; mc_ready at cycle 5 with mc_res=0x00100093. Expect if_ready and if_data=0x00100093 at cycle 5, mc_valid high cycles 1–5.
- Simultaneous ST (0x2000, data 0xDEADBEEF, size 2), LD (0x3000) and IF. Expect grant order ST, LD, IF; each mc_valid rises 2 cycles after the previous mc_ready.
- Starvation, STARVE_LIMIT=3: LD and ST kept valid continuously, if_valid high. Expect IF granted at the first arbitration after if has waited 3 cycles, despite ld_valid and st_valid being high.
- Flush during load: grant LD in BUSY, rob_clear with mc_ready in the same cycle. Expect ld_ready=0, mc_abort=1 for one cycle, then IDLE; counter 0.
- Flush during store: grant ST, rob_clear mid-transaction. Expect no mc_abort, st_ready on mc_ready; pending IF masked in the flush cycle.
- rdy_in low for 4 cycles mid-BUSY with mc_ready pulsed: no ready output; state and mc_addr unchanged. Async reset mid-BUSY: mc_valid=0 and busy=0 immediately.
